// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
package imem_port_arbiter_pkg;

  localparam int ADDR_W_DEF       = 8;
  localparam int DATA_W_DEF       = 8;
  localparam int STARVE_LIMIT_DEF = 4;

  // Which requester owns the read data returning from memory this cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_HOST  = 2'd2
  } owner_e;

  // OPEN: normal fetch/host arbitration. LOCKED: host owns the memory.
  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Bits needed to count 0..limit inclusive.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch, host and memory-side signals around the arbiter.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // Fetch path
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              cpu_stall;
  // Host loader/debug path
  logic              h_req;
  logic              h_we;
  logic              h_lock;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;
  // Memory command/return
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  // Arbiter side
  modport slave (
    input  f_req, f_addr, h_req, h_we, h_lock, h_addr, h_wdata, m_rdata,
    output f_gnt, f_rvalid, f_rdata, cpu_stall,
    output h_gnt, h_rvalid, h_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

  // Requester and memory side
  modport master (
    output f_req, f_addr, h_req, h_we, h_lock, h_addr, h_wdata, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, cpu_stall,
    input  h_gnt, h_rvalid, h_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Arbiter for a single-port synchronous instruction memory shared by the
// CPU fetch path and a host loader. One access per cycle, zero-latency
// grant, one-cycle read return routed to the winner, host lock mode.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic                 CLK,
  input logic                 CLB,
  imem_port_arbiter_if.slave  bus
);

  localparam int            CW    = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_e        state_q;
  owner_e        owner_q;
  logic [CW-1:0] starve_q;

  logic f_gnt;
  logic h_gnt;

  // Grant decision: host wins in LOCKED or once starved, otherwise fetch first.
  always_comb begin
    // NOTE: every output gets a default before the branches so no latch is inferred.
    f_gnt = 1'b0;
    h_gnt = 1'b0;
    if (state_q == ST_LOCKED) begin
      h_gnt = bus.h_req;
    end else if (bus.h_req && (starve_q == LIMIT)) begin
      h_gnt = 1'b1;
    end else if (bus.f_req) begin
      f_gnt = 1'b1;
    end else if (bus.h_req) begin
      h_gnt = 1'b1;
    end
  end

  // Memory command mux from the winner; zeros when idle.
  always_comb begin
    bus.m_en    = f_gnt | h_gnt;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    if (h_gnt) begin
      bus.m_we    = bus.h_we;
      bus.m_addr  = bus.h_addr;
      bus.m_wdata = bus.h_wdata;
    end else if (f_gnt) begin
      bus.m_addr  = bus.f_addr;
    end
  end

  // Lock FSM, starvation counter and read-return owner.
  always_ff @(posedge CLK) begin
    if (CLB) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q  <= ST_OPEN;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      case (state_q)
        ST_OPEN:   if (h_gnt && bus.h_lock) state_q <= ST_LOCKED;
        ST_LOCKED: if (!bus.h_lock)         state_q <= ST_OPEN;
        default:                            state_q <= ST_OPEN;
      endcase

      // Counts host cycles lost to fetch; frozen while the host holds the lock.
      if (state_q == ST_OPEN) begin
        if (!bus.h_req || h_gnt) begin
          starve_q <= '0;
        end else if (f_gnt && (starve_q != LIMIT)) begin
          starve_q <= starve_q + 1'b1;
        end
      end

      if (f_gnt)                   owner_q <= OWN_FETCH;
      else if (h_gnt && !bus.h_we) owner_q <= OWN_HOST;
      else                         owner_q <= OWN_NONE;
    end
  end

  assign bus.f_gnt     = f_gnt;
  assign bus.h_gnt     = h_gnt;
  assign bus.cpu_stall = (state_q == ST_LOCKED) || (bus.f_req && !f_gnt);
  assign bus.f_rvalid  = (owner_q == OWN_FETCH);
  assign bus.h_rvalid  = (owner_q == OWN_HOST);
  assign bus.f_rdata   = (owner_q == OWN_FETCH) ? bus.m_rdata : '0;
  assign bus.h_rdata   = (owner_q == OWN_HOST)  ? bus.m_rdata : '0;

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbiter for the single-port synchronous instruction memory shared by two requesters: the processor fetch path (program counter → instruction register) and a host loader/debug port. It grants at most one access per cycle, routes one-cycle-latency read data back to the winner, and supports a host lock mode for program loading that stalls fetch. It sits between the program counter and instruction register on one side and the instruction memory on the other.

## Interface
Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, instruction/data width
- STARVE_LIMIT, 4, consecutive denied host cycles before the host wins over fetch (≥1)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- CLB  in  1  reset, synchronous, active-high
- f_req  in  1  fetch read request; held with f_addr stable until f_gnt
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_rvalid  out  1  f_rdata valid (registered)
- f_rdata  out  DATA_W  fetch read data
- cpu_stall  out  1  fetch held off: LOCKED, or f_req && !f_gnt
- h_req, h_we, h_lock  in  1 each  host request, write enable, bus lock
- h_addr  in  ADDR_W; h_wdata  in  DATA_W
- h_gnt  out  1  host granted this cycle (combinational)
- h_rvalid  out  1; h_rdata  out  DATA_W  host read return
- m_en, m_we  out  1 each; m_addr  out  ADDR_W; m_wdata  out  DATA_W  memory command
- m_rdata  in  DATA_W  memory read data, valid the cycle after m_en && !m_we

## Operation
- States: OPEN, LOCKED. Reset → OPEN.
- OPEN grant: if h_req && starve_cnt == STARVE_LIMIT → host; else if f_req → fetch; else if h_req → host; else none.
- LOCKED grant: host iff h_req; fetch never granted.
- OPEN → LOCKED: host granted with h_lock=1. LOCKED → OPEN: cycle with h_lock=0 (that cycle's host access still granted; fetch waits until next cycle).
- starve_cnt: 0 when !h_req or h_gnt; else +1 when h_req && f_gnt, saturating at STARVE_LIMIT; held in LOCKED.
- m_en = f_gnt | h_gnt; m_addr/m_we/m_wdata muxed from winner; fetch always reads (m_we=0). Ungranted: m_en=0, other memory outputs 0.
- Read return: owner register (NONE/FETCH/HOST) captured on a granted read; next cycle raise matching rvalid and pass m_rdata to that rdata. Writes produce no rvalid. Unselected rdata = 0.
- Dropping req before gnt is a legal abort; no state change beyond starve_cnt rule.

## Timing
- Reset values: f_gnt, h_gnt, f_rvalid, h_rvalid, m_en, m_we = 0; rdata/m_addr/m_wdata = 0; cpu_stall = 0 unless f_req; starve_cnt 0; owner NONE; state OPEN.
- Grant latency 0 cycles (same cycle as req if winning); read latency 1 cycle after grant; throughput one access/cycle, back-to-back grants allowed.
- Simultaneous f_req && h_req, starve_cnt < limit → fetch; = limit → host, counter clears next cycle.
- CLB mid-read: pending rvalid squashed (not asserted the cycle after reset); lock released.
- h_lock sampled only on host grants in OPEN, every cycle in LOCKED.

## Structure
- Shared package: owner enum (NONE, FETCH, HOST), state enum (OPEN, LOCKED), default ADDR_W/DATA_W/STARVE_LIMIT.
- Single module; grant logic combinational, state/starve_cnt/owner registers in one sequential process. No sub-module required.

## Test plan
- Fetch only: f_req=1, f_addr=0x10, memory holds 0xA5 → f_gnt same cycle, m_addr=0x10, next cycle f_rvalid=1, f_rdata=0xA5, cpu_stall=0.
- Contention: f_req and h_req (read 0x20) held continuously, STARVE_LIMIT=4 → fetch granted cycles 0-3, host granted cycle 4, fetch again cycle 5; h_rvalid at cycle 5.
- Host write: h_req=1, h_we=1, h_addr=0x05, h_wdata=0x3C → m_en=1, m_we=1, no rvalid; later fetch of 0x05 returns 0x3C.
- Lock burst: host writes 0x00..0x03 with h_lock=1 while f_req=1 → f_gnt=0, cpu_stall=1 throughout; drop h_lock → fetch granted the following cycle.
- Reset mid-read: fetch read granted, CLB=1 next edge → f_rvalid=0 after reset, state OPEN, starve_cnt 0.
- Abort: h_req for 2 denied cycles then dropped → starve_cnt returns 0; next contention gives fetch 4 more grants first.
